store_rmw_unit: RTL

STORE_RMW_UNIT -- requirements
Module: store_rmw_unit

---
 rtl/store_rmw_unit_pkg.sv | 35 +++
 rtl/store_rmw_unit_lane_merge.sv | 45 ++++
 rtl/store_rmw_unit.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/store_rmw_unit_pkg.sv
// Shared definitions for the store read-modify-write unit.
//   - Store size encodings carried on req_size.
//   - FSM state enumeration used by store_rmw_unit.
//   - Alignment helper shared by the FSM.
package store_rmw_unit_pkg;

  localparam logic [1:0] SIZE_BYTE    = 2'b00;
  localparam logic [1:0] SIZE_HALF    = 2'b01;
  localparam logic [1:0] SIZE_WORD    = 2'b10;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WRITE = 3'd2,
    ST_RESP  = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

  // A request is rejected when its address is not naturally aligned to its
  // size, or when the size encoding is the reserved value.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b1;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = addr_lo[0];
      SIZE_WORD: bad = (addr_lo != 2'b00);
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/store_rmw_unit_lane_merge.sv
// store_lane_merge: combinational little-endian lane merge.
// Ports:
//   old_word - word read back from memory
//   data     - store data, sub-word value in the low bits
//   size     - store size encoding (byte / half / word)
//   lane     - byte address bits [1:0] of the store
//   merged   - old_word with the addressed lane(s) replaced by data
// Bits of data above the store size are dropped. The reserved size leaves
// old_word untouched (such requests never reach the write phase anyway).
module store_lane_merge
  import store_rmw_unit_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] data,
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  output logic [31:0] merged
);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte
      logic sel_byte;
      logic sel_half;
      logic sel_word;

      assign sel_byte = (size == SIZE_BYTE) && (lane == 2'(gi));
      // Bytes 0/1 form the low half, bytes 2/3 the high half.
      assign sel_half = (size == SIZE_HALF) && (lane[1] == 1'(gi / 2));
      assign sel_word = (size == SIZE_WORD);

      always_comb begin
        merged[8*gi +: 8] = old_word[8*gi +: 8];
        if (sel_word) begin
          merged[8*gi +: 8] = data[8*gi +: 8];
        end else if (sel_half) begin
          merged[8*gi +: 8] = data[8*(gi % 2) +: 8];
        end else if (sel_byte) begin
          merged[8*gi +: 8] = data[7:0];
        end
      end
    end
  endgenerate

endmodule

// File: rtl/store_rmw_unit.sv
// store_rmw_unit: performs byte/half/word stores against a word-wide memory.
// Sub-word stores read the containing word, merge the new lane(s) and write
// the full word back; word stores write directly. Misaligned or reserved-size
// requests are rejected with a single-cycle misalign_err pulse.
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   req_valid/req_ready   - request handshake (ready only while idle)
//   req_addr/data/size    - byte address, store value, size (00 B,01 H,10 W)
//   mem_addr              - word address (low two bits zero)
//   mem_rd/mem_rdata/mem_rvalid - read strobe held until rvalid, read data
//   mem_wr/mem_wdata/mem_ack    - write strobe held until ack, merged word
//   done                  - one-cycle pulse when a store completes
//   misalign_err          - one-cycle pulse when a request is rejected
// All outputs are registered directly by the FSM.
module store_rmw_unit
  import store_rmw_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  input  logic [1:0]            req_size,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rvalid,
  output logic                  mem_wr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  output logic                  done,
  output logic                  misalign_err
);

  state_e                state_reg;
  logic                  req_ready_reg;
  logic                  mem_rd_reg;
  logic                  mem_wr_reg;
  logic                  done_reg;
  logic                  err_reg;
  logic [ADDR_WIDTH-1:0] mem_addr_reg;
  logic [DATA_WIDTH-1:0] mem_wdata_reg;
  logic [DATA_WIDTH-1:0] data_reg;
  logic [1:0]            size_reg;
  logic [1:0]            lane_reg;
  logic [DATA_WIDTH-1:0] merged_word;

  // Merge is driven from the captured request, so the request inputs may
  // change freely once accepted.
  store_lane_merge u_merge (
    .old_word (mem_rdata),
    .data     (data_reg),
    .size     (size_reg),
    .lane     (lane_reg),
    .merged   (merged_word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      req_ready_reg <= 1'b0;
      mem_rd_reg    <= 1'b0;
      mem_wr_reg    <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      data_reg      <= '0;
      size_reg      <= SIZE_BYTE;
      lane_reg      <= 2'b00;
    end else begin
      // Status pulses last exactly one cycle.
      done_reg <= 1'b0;
      err_reg  <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          // Ready rises on the first edge after reset and stays up while idle.
          req_ready_reg <= 1'b1;
          if (req_valid && req_ready_reg) begin
            req_ready_reg <= 1'b0;
            data_reg      <= req_data;
            size_reg      <= req_size;
            lane_reg      <= req_addr[1:0];
            mem_addr_reg  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
            if (is_misaligned(req_size, req_addr[1:0])) begin
              state_reg <= ST_ERR;
              err_reg   <= 1'b1;
            end else if (req_size == SIZE_WORD) begin
              // Full-word store needs no read-back.
              state_reg     <= ST_WRITE;
              mem_wr_reg    <= 1'b1;
              mem_wdata_reg <= req_data;
            end else begin
              state_reg  <= ST_READ;
              mem_rd_reg <= 1'b1;
            end
          end
        end

        ST_READ: begin
          if (mem_rvalid) begin
            state_reg     <= ST_WRITE;
            mem_rd_reg    <= 1'b0;
            mem_wr_reg    <= 1'b1;
            mem_wdata_reg <= merged_word;
          end
        end

        ST_WRITE: begin
          if (mem_ack) begin
            state_reg  <= ST_RESP;
            mem_wr_reg <= 1'b0;
            done_reg   <= 1'b1;
          end
        end

        ST_RESP: begin
          state_reg     <= ST_IDLE;
          req_ready_reg <= 1'b1;
        end

        ST_ERR: begin
          state_reg     <= ST_IDLE;
          req_ready_reg <= 1'b1;
        end

        default: begin
          state_reg     <= ST_IDLE;
          req_ready_reg <= 1'b0;
          mem_rd_reg    <= 1'b0;
          mem_wr_reg    <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready    = req_ready_reg;
  assign mem_rd       = mem_rd_reg;
  assign mem_wr       = mem_wr_reg;
  assign done         = done_reg;
  assign misalign_err = err_reg;
  assign mem_addr     = mem_addr_reg;
  assign mem_wdata    = mem_wdata_reg;

endmodule
